// File: rtl/vend_pkg.sv
// Shared definitions for the status monitor: display codes, FSM state, segment patterns.
// Latency: none (constants and a pure combinational helper).
// Backpressure: not applicable.
package vend_pkg;

    localparam logic [3:0] RES_OK    = 4'b1111;
    localparam logic [3:0] RES_WRONG = 4'b0000;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_OK    = 7'b1110001;  // "F"
    localparam logic [6:0] SEG_WRONG = 7'b0111111;  // "0"

    typedef enum logic {
        SCAN = 1'b0,
        LOCK = 1'b1
    } disp_state_t;

    // Full hex to seven-segment table.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Registered hex to seven-segment decoder ({g,f,e,d,c,b,a}, active-high).
// Latency: 1 cycle from value to seg.
// Backpressure: none; decodes every cycle.
module seg7_decode
    import vend_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Register the decoded pattern; reset shows the "ok" glyph.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            seg <= SEG_OK;
        end else begin
            seg <= hex_to_seg(value);
        end
    end

endmodule

// File: rtl/vend_status_monitor.sv
// Latches per-channel faults, scans or locks the display onto faulty channels, drives a 7-seg glyph.
// Latency: check -> fault_vec/redlight/disp_ch 1 cycle, -> result/sevensegment 2 cycles.
// Backpressure: none; optional fault event counter enabled by VEND_FAULT_COUNT_EN.
module vend_status_monitor
    import vend_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DWELL  = 1000,
    parameter int CNT_W  = 8
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic [2*NUM_CH-1:0]                      check,
    input  logic                                     clear,
    output logic                                     redlight,
    output logic [NUM_CH-1:0]                        fault_vec,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] disp_ch,
    output logic [3:0]                               result,
    output logic [6:0]                               sevensegment
`ifdef VEND_FAULT_COUNT_EN
    ,
    output logic [CNT_W-1:0]                         fault_count
`endif
);

    localparam int DW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [NUM_CH-1:0] wrong_vec;
    logic [NUM_CH-1:0] fault_nxt;
    logic [DW-1:0]     low_idx;
    disp_state_t       state;
    disp_state_t       state_nxt;
    logic [CW-1:0]     dwell_cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [DW-1:0]     disp_nxt;
    logic [3:0]        result_nxt;

    // Next fault flags (set wins over clear) and the lowest flagged channel.
    always_comb begin
        wrong_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wrong_vec[i] = (check[2*i +: 2] != 2'b00);
        end
        fault_nxt = clear ? wrong_vec : (fault_vec | wrong_vec);
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fault_nxt[i]) begin
                low_idx = DW'(i);
            end
        end
    end

    // Display FSM: scan with dwell timer, or lock onto the lowest faulty channel.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = dwell_cnt;
        disp_nxt  = disp_ch;
        case (state)
            SCAN: begin
                if (|fault_nxt) begin
                    state_nxt = LOCK;
                    cnt_nxt   = '0;
                    disp_nxt  = low_idx;
                end else if (dwell_cnt == CW'(DWELL - 1)) begin
                    cnt_nxt  = '0;
                    disp_nxt = (disp_ch == DW'(NUM_CH - 1)) ? '0 : disp_ch + 1'b1;
                end else begin
                    cnt_nxt = dwell_cnt + 1'b1;
                end
            end
            LOCK: begin
                cnt_nxt = '0;
                if (fault_nxt == '0) begin
                    state_nxt = SCAN;
                    disp_nxt  = '0;
                end else begin
                    disp_nxt = low_idx;
                end
            end
        endcase
        result_nxt = fault_vec[disp_ch] ? RES_WRONG : RES_OK;
    end

    // State, flags and displayed code; reset beats clear and check.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= SCAN;
            dwell_cnt <= '0;
            disp_ch   <= '0;
            fault_vec <= '0;
            redlight  <= 1'b0;
            result    <= RES_OK;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= cnt_nxt;
            disp_ch   <= disp_nxt;
            fault_vec <= fault_nxt;
            redlight  <= |fault_nxt;
            result    <= result_nxt;
        end
    end

    // Segments decode result_nxt so they update on the same edge as result.
    seg7_decode u_seg7 (
        .clock   (clock),
        .reset_n (reset_n),
        .value   (result_nxt),
        .seg     (sevensegment)
    );

`ifdef VEND_FAULT_COUNT_EN
    localparam int SW = CNT_W + 5;

    logic [SW-1:0] new_pop;
    logic [SW-1:0] cnt_sum;

    // Count newly set flags this cycle; wide sum so saturation can be detected.
    always_comb begin
        new_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            new_pop = new_pop + SW'(fault_nxt[i] & ~fault_vec[i]);
        end
        cnt_sum = SW'(fault_count) + new_pop;
    end

    // Saturating event counter, untouched by clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fault_count <= '0;
        end else if (cnt_sum > SW'({CNT_W{1'b1}})) begin
            fault_count <= '1;
        end else begin
            fault_count <= cnt_sum[CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_vend_status_monitor.sv
// Vector-table bench for vend_status_monitor (NUM_CH=4, DWELL=4, CNT_W=2).
// Expected values queued at drive time, popped and compared 1 time unit after the edge.
// Fault counter checks compile in only when VEND_FAULT_COUNT_EN is defined.
module tb_vend_status_monitor;

    localparam int NUM_CH = 4;
    localparam int DWELL  = 4;
    localparam int CNT_W  = 2;

    localparam logic [3:0] R_OK = 4'b1111;
    localparam logic [3:0] R_WR = 4'b0000;
    localparam logic [6:0] S_OK = 7'h71;
    localparam logic [6:0] S_WR = 7'h3F;

    typedef struct {
        logic       rst_n;
        logic       clr;
        logic [7:0] chk;
        logic [3:0] fv;
        logic       red;
        logic [1:0] disp;
        logic [3:0] res;
        logic [6:0] seg;
        int         cnt;   // -1: not checked
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] check = 8'h00;
    logic       clear = 1'b0;
    logic       redlight;
    logic [3:0] fault_vec;
    logic [1:0] disp_ch;
    logic [3:0] result;
    logic [6:0] sevensegment;
`ifdef VEND_FAULT_COUNT_EN
    logic [CNT_W-1:0] fault_count;
`endif

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    vend_status_monitor #(.NUM_CH(NUM_CH), .DWELL(DWELL), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .check        (check),
        .clear        (clear),
        .redlight     (redlight),
        .fault_vec    (fault_vec),
        .disp_ch      (disp_ch),
        .result       (result),
        .sevensegment (sevensegment)
`ifdef VEND_FAULT_COUNT_EN
        ,
        .fault_count  (fault_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic add(input logic r, input logic c, input logic [7:0] k, input logic [3:0] fv,
                       input logic red, input logic [1:0] d, input logic [3:0] res,
                       input logic [6:0] seg, input int cnt);
        vec_t v;
        v.rst_n = r; v.clr = c; v.chk = k; v.fv = fv; v.red = red;
        v.disp = d; v.res = res; v.seg = seg; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        // Scan after reset: disp_ch advances every DWELL cycles and wraps.
        add(0, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, 0);
        for (int n = 1; n <= 17; n++)
            add(1, 0, 8'h00, 4'h0, 0, 2'((n / 4) % 4), R_OK, S_OK, -1);
        // Single-cycle fault on ch2, held after check returns to ok.
        add(0, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, 0);
        add(1, 0, 8'h10, 4'h4, 1, 2'd2, R_OK, S_OK, -1);
        add(1, 0, 8'h00, 4'h4, 1, 2'd2, R_WR, S_WR, -1);
        add(1, 0, 8'h00, 4'h4, 1, 2'd2, R_WR, S_WR, -1);
        add(1, 0, 8'h00, 4'h4, 1, 2'd2, R_WR, S_WR, -1);
        // ch3 then ch1: display moves to 1; clear returns to scanning from 0.
        add(0, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, 0);
        add(1, 0, 8'h40, 4'h8, 1, 2'd3, R_OK, S_OK, -1);
        add(1, 0, 8'h00, 4'h8, 1, 2'd3, R_WR, S_WR, -1);
        add(1, 0, 8'h0C, 4'hA, 1, 2'd1, R_WR, S_WR, -1);
        add(1, 0, 8'h00, 4'hA, 1, 2'd1, R_WR, S_WR, -1);
        add(1, 1, 8'h00, 4'h0, 0, 2'd0, R_WR, S_WR, -1);
        add(1, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, -1);
        add(1, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, -1);
        // Clear together with a new ch0 fault: set wins, redlight stays up.
        add(0, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, 0);
        add(1, 0, 8'h04, 4'h2, 1, 2'd1, R_OK, S_OK, -1);
        add(1, 1, 8'h02, 4'h1, 1, 2'd0, R_WR, S_WR, -1);
        add(1, 0, 8'h00, 4'h1, 1, 2'd0, R_WR, S_WR, -1);
        // Reset in LOCK with clear and all channels wrong: reset wins, scan restarts.
        add(0, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, 0);
        add(1, 0, 8'h10, 4'h4, 1, 2'd2, R_OK, S_OK, -1);
        add(1, 0, 8'h00, 4'h4, 1, 2'd2, R_WR, S_WR, -1);
        add(0, 1, 8'hFF, 4'h0, 0, 2'd0, R_OK, S_OK, 0);
        add(1, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, -1);
        add(1, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, -1);
        add(1, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, -1);
        add(1, 0, 8'h00, 4'h0, 0, 2'd1, R_OK, S_OK, -1);
        // Fault counter: two at once, clear, ch2, clear, ch2 again (saturates at 3).
        add(0, 0, 8'h00, 4'h0, 0, 2'd0, R_OK, S_OK, 0);
        add(1, 0, 8'h05, 4'h3, 1, 2'd0, R_OK, S_OK, 2);
        add(1, 1, 8'h00, 4'h0, 0, 2'd0, R_WR, S_WR, 2);
        add(1, 0, 8'h10, 4'h4, 1, 2'd2, R_OK, S_OK, 3);
        add(1, 1, 8'h00, 4'h0, 0, 2'd0, R_WR, S_WR, 3);
        add(1, 0, 8'h10, 4'h4, 1, 2'd2, R_OK, S_OK, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            reset_n = tbl[i].rst_n;
            clear   = tbl[i].clr;
            check   = tbl[i].chk;
            exp_q.push_back(tbl[i]);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            cmp("fault_vec",    i, 32'(fault_vec),    32'(e.fv));
            cmp("redlight",     i, 32'(redlight),     32'(e.red));
            cmp("disp_ch",      i, 32'(disp_ch),      32'(e.disp));
            cmp("result",       i, 32'(result),       32'(e.res));
            cmp("sevensegment", i, 32'(sevensegment), 32'(e.seg));
`ifdef VEND_FAULT_COUNT_EN
            if (e.cnt >= 0)
                cmp("fault_count", i, 32'(fault_count), 32'(e.cnt));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
